fft_out_streamer: RTL and testbench

//  Sits directly downstream of the 512-point FFT top. Captures one full bit-reversal-corrected

---
 rtl/fft_pkg.sv | 25 ++
 rtl/fft_frame_bank.sv | 51 +++++
 rtl/fft_out_streamer.sv | 176 +++++++++++++++++
 tb/tb_fft_out_streamer.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fft_pkg.sv
// Shared constants and types for the FFT output streamer.
// Holds the frame geometry, the bin type and the read-side FSM encoding.
package fft_pkg;

  localparam int TOTAL_SIZE = 512;
  localparam int WIDTH_OUT  = 13;
  localparam int LANES      = 16;
  localparam int BEATS      = TOTAL_SIZE / LANES;
  localparam int CNT_W      = 8;
  localparam int BEAT_W     = $clog2(BEATS);
  localparam int LANE_W     = $clog2(LANES);

  typedef logic signed [WIDTH_OUT-1:0] bin_t;

  typedef enum logic {
    IDLE,
    SEND
  } strm_state_t;

  // Increment that sticks at the all-ones value.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/fft_frame_bank.sv
// One frame bank of the ping-pong buffer.
// Ports:
//   clk      clock, rising edge
//   wr_en    capture all TOTAL_SIZE bins from wr_re/wr_im this edge
//   wr_re    real bins, all in parallel
//   wr_im    imag bins, all in parallel
//   rd_beat  beat index selecting bins [rd_beat*LANES +: LANES]
//   rd_re    LANES real bins of the selected beat (combinational)
//   rd_im    LANES imag bins of the selected beat (combinational)
// Storage has no reset: the full/empty status kept in the top decides
// whether the contents mean anything.
module fft_frame_bank
  import fft_pkg::*;
(
  input  logic                    clk,
  input  logic                    wr_en,
  input  bin_t [TOTAL_SIZE-1:0]   wr_re,
  input  bin_t [TOTAL_SIZE-1:0]   wr_im,
  input  logic [BEAT_W-1:0]       rd_beat,
  output bin_t [LANES-1:0]        rd_re,
  output bin_t [LANES-1:0]        rd_im
);

  bin_t [TOTAL_SIZE-1:0] re_q, re_d;
  bin_t [TOTAL_SIZE-1:0] im_q, im_d;

  always_comb begin
    re_d = re_q;
    im_d = im_q;
    if (wr_en) begin
      re_d = wr_re;
      im_d = wr_im;
    end
  end

  always_ff @(posedge clk) begin
    re_q <= re_d;
    im_q <= im_d;
  end

  // BEATS*LANES == TOTAL_SIZE, so {beat, lane} is exactly the bin address.
  always_comb begin
    rd_re = '0;
    rd_im = '0;
    for (int j = 0; j < LANES; j++) begin
      rd_re[j] = re_q[{rd_beat, LANE_W'(j)}];
      rd_im[j] = im_q[{rd_beat, LANE_W'(j)}];
    end
  end

endmodule

// File: rtl/fft_out_streamer.sv
// Captures whole FFT frames into a two-bank ping-pong buffer and streams
// them out LANES bins per beat, bin 0 first, with valid/ready handshake.
// Ports:
//   clk, rstn           clock (rising) and async active-low reset
//   fft_en              1-cycle frame strobe; fft_re/fft_im valid with it
//   fft_re, fft_im      TOTAL_SIZE signed bins each
//   m_valid, m_ready    output handshake; beat moves when both are high
//   m_re, m_im          LANES bins of the current beat
//   m_beat, m_last      beat index and last-beat flag
//   frame_drop          1-cycle pulse when fft_en found no free bank
//   drop_cnt            saturating dropped-frame count
//   busy                a bank is full or a beat is pending
// Timing: fft_en sampled at edge k writes the bank; edge k+1 loads beat 0
// into the output register, so beat 0 can be transferred at edge k+2.
module fft_out_streamer
  import fft_pkg::*;
(
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  fft_en,
  input  bin_t [TOTAL_SIZE-1:0] fft_re,
  input  bin_t [TOTAL_SIZE-1:0] fft_im,
  output logic                  m_valid,
  input  logic                  m_ready,
  output bin_t [LANES-1:0]      m_re,
  output bin_t [LANES-1:0]      m_im,
  output logic [BEAT_W-1:0]     m_beat,
  output logic                  m_last,
  output logic                  frame_drop,
  output logic [CNT_W-1:0]      drop_cnt,
  output logic                  busy
);

  strm_state_t          state_q, state_d;
  logic [BEAT_W-1:0]    beat_q, beat_d;
  logic [1:0]           full_q, full_d;
  logic                 wr_sel_q, wr_sel_d;
  logic                 rd_sel_q, rd_sel_d;
  bin_t [LANES-1:0]     out_re_q, out_re_d;
  bin_t [LANES-1:0]     out_im_q, out_im_d;
  logic                 drop_q, drop_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;

  logic                 load;
  logic                 rd_bank;
  logic [BEAT_W-1:0]    rd_beat;
  logic [1:0]           bank_wr_en;
  bin_t [LANES-1:0]     bank_re [2];
  bin_t [LANES-1:0]     bank_im [2];
  logic                 last_beat;

  fft_frame_bank u_bank0 (
    .clk     (clk),
    .wr_en   (bank_wr_en[0]),
    .wr_re   (fft_re),
    .wr_im   (fft_im),
    .rd_beat (rd_beat),
    .rd_re   (bank_re[0]),
    .rd_im   (bank_im[0])
  );

  fft_frame_bank u_bank1 (
    .clk     (clk),
    .wr_en   (bank_wr_en[1]),
    .wr_re   (fft_re),
    .wr_im   (fft_im),
    .rd_beat (rd_beat),
    .rd_re   (bank_re[1]),
    .rd_im   (bank_im[1])
  );

  assign last_beat = (beat_q == BEAT_W'(BEATS - 1));

  always_comb begin
    state_d    = state_q;
    beat_d     = beat_q;
    full_d     = full_q;
    wr_sel_d   = wr_sel_q;
    rd_sel_d   = rd_sel_q;
    drop_d     = 1'b0;
    cnt_d      = cnt_q;
    bank_wr_en = 2'b00;
    load       = 1'b0;
    rd_bank    = rd_sel_q;
    rd_beat    = beat_q;

    // Capture decision uses full_q from before the edge, so a bank being
    // released this same cycle is not yet available to this fft_en.
    if (fft_en) begin
      if (!full_q[wr_sel_q]) begin
        bank_wr_en[wr_sel_q] = 1'b1;
        full_d[wr_sel_q]     = 1'b1;
        wr_sel_d             = ~wr_sel_q;
      end else begin
        drop_d = 1'b1;
        cnt_d  = sat_inc(cnt_q);
      end
    end

    case (state_q)
      IDLE: begin
        if (full_q[rd_sel_q]) begin
          state_d = SEND;
          beat_d  = '0;
          rd_beat = '0;
          load    = 1'b1;
        end
      end
      SEND: begin
        if (m_ready) begin
          if (last_beat) begin
            full_d[rd_sel_q] = 1'b0;
            rd_sel_d         = ~rd_sel_q;
            beat_d           = '0;
            // Chain straight into the other bank when it already holds a frame.
            if (full_q[~rd_sel_q]) begin
              rd_bank = ~rd_sel_q;
              rd_beat = '0;
              load    = 1'b1;
            end else begin
              state_d = IDLE;
            end
          end else begin
            beat_d  = beat_q + 1'b1;
            rd_beat = beat_q + 1'b1;
            load    = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    out_re_d = out_re_q;
    out_im_d = out_im_q;
    if (load) begin
      out_re_d = bank_re[rd_bank];
      out_im_d = bank_im[rd_bank];
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= IDLE;
      beat_q   <= '0;
      full_q   <= 2'b00;
      wr_sel_q <= 1'b0;
      rd_sel_q <= 1'b0;
      out_re_q <= '0;
      out_im_q <= '0;
      drop_q   <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      beat_q   <= beat_d;
      full_q   <= full_d;
      wr_sel_q <= wr_sel_d;
      rd_sel_q <= rd_sel_d;
      out_re_q <= out_re_d;
      out_im_q <= out_im_d;
      drop_q   <= drop_d;
      cnt_q    <= cnt_d;
    end
  end

  assign m_valid    = (state_q == SEND);
  assign m_re       = out_re_q;
  assign m_im       = out_im_q;
  assign m_beat     = beat_q;
  assign m_last     = (state_q == SEND) && last_beat;
  assign frame_drop = drop_q;
  assign drop_cnt   = cnt_q;
  assign busy       = (|full_q) || (state_q == SEND);

endmodule

// File: tb/tb_fft_out_streamer.sv
// Directed self-checking bench for fft_out_streamer.
// Frame pattern p: bin n has re = n - 256 + 1000*p, im = 255 - n - 1000*p.
module tb_fft_out_streamer;
  import fft_pkg::*;

  localparam int VW = LANES * WIDTH_OUT;
  typedef logic [VW-1:0] vec_t;

  logic                  clk;
  logic                  rstn;
  logic                  fft_en;
  bin_t [TOTAL_SIZE-1:0] fft_re;
  bin_t [TOTAL_SIZE-1:0] fft_im;
  logic                  m_valid;
  logic                  m_ready;
  bin_t [LANES-1:0]      m_re;
  bin_t [LANES-1:0]      m_im;
  logic [BEAT_W-1:0]     m_beat;
  logic                  m_last;
  logic                  frame_drop;
  logic [CNT_W-1:0]      drop_cnt;
  logic                  busy;

  int assertCount = 0;
  int failCount   = 0;

  fft_out_streamer dut (
    .clk        (clk),
    .rstn       (rstn),
    .fft_en     (fft_en),
    .fft_re     (fft_re),
    .fft_im     (fft_im),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_re       (m_re),
    .m_im       (m_im),
    .m_beat     (m_beat),
    .m_last     (m_last),
    .frame_drop (frame_drop),
    .drop_cnt   (drop_cnt),
    .busy       (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic bin_t binRe(input int p, input int n);
    return bin_t'(n - 256 + 1000 * p);
  endfunction

  function automatic bin_t binIm(input int p, input int n);
    return bin_t'(255 - n - 1000 * p);
  endfunction

  function automatic vec_t expBeat(input int p, input int b, input bit im);
    bin_t [LANES-1:0] v;
    for (int j = 0; j < LANES; j++)
      v[j] = im ? binIm(p, b * LANES + j) : binRe(p, b * LANES + j);
    return vec_t'(v);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input vec_t obs, input vec_t exp);
    assertCount++;
    assert (obs === exp) else begin
      failCount++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input bit en, input int p);
    fft_en = en;
    for (int n = 0; n < TOTAL_SIZE; n++) begin
      fft_re[n] = binRe(p, n);
      fft_im[n] = binIm(p, n);
    end
  endtask

  task automatic checkReset(input string tag);
    checkOutput($sformatf("%s_valid", tag), vec_t'(m_valid), vec_t'(0));
    checkOutput($sformatf("%s_beat", tag), vec_t'(m_beat), vec_t'(0));
    checkOutput($sformatf("%s_last", tag), vec_t'(m_last), vec_t'(0));
    checkOutput($sformatf("%s_drop", tag), vec_t'(frame_drop), vec_t'(0));
    checkOutput($sformatf("%s_cnt", tag), vec_t'(drop_cnt), vec_t'(0));
    checkOutput($sformatf("%s_busy", tag), vec_t'(busy), vec_t'(0));
    checkOutput($sformatf("%s_re", tag), vec_t'(m_re), vec_t'(0));
    checkOutput($sformatf("%s_im", tag), vec_t'(m_im), vec_t'(0));
  endtask

  task automatic applyReset(input string tag);
    rstn    = 1'b0;
    fft_en  = 1'b0;
    m_ready = 1'b0;
    #2;
    checkReset(tag);
    tick();
    tick();
    rstn = 1'b1;
    tick();
  endtask

  // Called one step after the edge that loads beat 0. Each cycle checks the
  // presented beat, then decides m_ready; the beat index advances only on
  // a real transfer. Optionally injects an fft_en pulse at cycle injAt.
  task automatic streamFrame(input string tag, input int p, input bit toggle,
                             input int stallBeat, input int stallLen,
                             input int stopBeat, input int injAt, input int injP,
                             input bit spot);
    int  b = 0;
    int  c = 0;
    int  stalled = 0;
    bit  rdy;
    bit  spotDone = 0;
    while (b < stopBeat && c < 400) begin
      rdy = toggle ? (c % 2 == 0) : 1'b1;
      if (b == stallBeat && stalled < stallLen) begin
        rdy = 1'b0;
        stalled++;
      end
      m_ready = rdy;
      if (c == injAt) applyStimulus(1'b1, injP);
      else fft_en = 1'b0;
      checkOutput($sformatf("%s_valid_b%0d", tag, b), vec_t'(m_valid), vec_t'(1));
      checkOutput($sformatf("%s_beat_b%0d", tag, b), vec_t'(m_beat), vec_t'(b));
      checkOutput($sformatf("%s_last_b%0d", tag, b), vec_t'(m_last), vec_t'(b == BEATS - 1));
      checkOutput($sformatf("%s_re_b%0d", tag, b), vec_t'(m_re), expBeat(p, b, 1'b0));
      checkOutput($sformatf("%s_im_b%0d", tag, b), vec_t'(m_im), expBeat(p, b, 1'b1));
      checkOutput($sformatf("%s_nodrop_b%0d", tag, b), vec_t'(frame_drop), vec_t'(0));
      if (spot && b == 5 && !spotDone) begin
        checkOutput($sformatf("%s_b5l3_re", tag), vec_t'(m_re[3]), vec_t'(bin_t'(-173)));
        checkOutput($sformatf("%s_b5l3_im", tag), vec_t'(m_im[3]), vec_t'(bin_t'(172)));
        spotDone = 1;
      end
      if (rdy && m_valid === 1'b1) b++;
      c++;
      tick();
    end
    fft_en = 1'b0;
    checkOutput($sformatf("%s_beats_done", tag), vec_t'(b), vec_t'(stopBeat));
  endtask

  task automatic checkIdle(input string tag);
    checkOutput($sformatf("%s_valid", tag), vec_t'(m_valid), vec_t'(0));
    checkOutput($sformatf("%s_last", tag), vec_t'(m_last), vec_t'(0));
    checkOutput($sformatf("%s_busy", tag), vec_t'(busy), vec_t'(0));
  endtask

  initial begin
    rstn    = 1'b0;
    m_ready = 1'b0;
    applyStimulus(1'b0, 0);
    tick();
    applyReset("reset0");

    $display("[TB] test 1: single frame, m_ready=1");
    applyStimulus(1'b1, 0);
    tick();
    fft_en = 1'b0;
    checkOutput("t1_lat_valid", vec_t'(m_valid), vec_t'(0));
    checkOutput("t1_lat_busy", vec_t'(busy), vec_t'(1));
    tick();
    streamFrame("t1", 0, 1'b0, -1, 0, BEATS, -1, 0, 1'b1);
    checkIdle("t1_end");

    $display("[TB] test 2: toggling m_ready with stall at beat 7");
    applyStimulus(1'b1, 0);
    tick();
    fft_en = 1'b0;
    tick();
    streamFrame("t2", 0, 1'b1, 7, 10, BEATS, -1, 0, 1'b1);
    checkIdle("t2_end");

    $display("[TB] test 3: back-to-back frames");
    applyStimulus(1'b1, 1);
    tick();
    fft_en = 1'b0;
    tick();
    streamFrame("t3a", 1, 1'b0, -1, 0, BEATS, 30, 2, 1'b0);
    streamFrame("t3b", 2, 1'b0, -1, 0, BEATS, -1, 0, 1'b0);
    checkIdle("t3_end");

    $display("[TB] test 4: drop with both banks full");
    applyReset("reset4");
    applyStimulus(1'b1, 1);
    tick();
    fft_en = 1'b0;
    tick();
    applyStimulus(1'b1, 2);
    tick();
    fft_en = 1'b0;
    tick();
    checkOutput("t4_nodrop", vec_t'(frame_drop), vec_t'(0));
    applyStimulus(1'b1, 3);
    tick();
    fft_en = 1'b0;
    checkOutput("t4_drop_pulse", vec_t'(frame_drop), vec_t'(1));
    checkOutput("t4_drop_cnt", vec_t'(drop_cnt), vec_t'(1));
    tick();
    checkOutput("t4_drop_clear", vec_t'(frame_drop), vec_t'(0));
    checkOutput("t4_drop_cnt_hold", vec_t'(drop_cnt), vec_t'(1));
    checkOutput("t4_busy", vec_t'(busy), vec_t'(1));
    streamFrame("t4f1", 1, 1'b0, -1, 0, BEATS, -1, 0, 1'b0);
    streamFrame("t4f2", 2, 1'b0, -1, 0, BEATS, -1, 0, 1'b0);
    checkIdle("t4_end");

    $display("[TB] test 5: reset mid-stream");
    applyStimulus(1'b1, 3);
    tick();
    fft_en = 1'b0;
    tick();
    streamFrame("t5pre", 3, 1'b0, -1, 0, 12, -1, 0, 1'b0);
    m_ready = 1'b0;
    applyReset("t5_rst");
    checkIdle("t5_after_rst");
    applyStimulus(1'b1, 0);
    tick();
    fft_en = 1'b0;
    checkOutput("t5_lat_valid", vec_t'(m_valid), vec_t'(0));
    tick();
    streamFrame("t5", 0, 1'b0, -1, 0, BEATS, -1, 0, 1'b0);
    checkIdle("t5_end");

    $display("[TB] test 6: drop counter saturation");
    m_ready = 1'b0;
    applyStimulus(1'b1, 1);
    tick();
    fft_en = 1'b0;
    tick();
    applyStimulus(1'b1, 2);
    tick();
    fft_en = 1'b0;
    tick();
    for (int i = 0; i < 300; i++) begin
      applyStimulus(1'b1, 3);
      tick();
      fft_en = 1'b0;
      if (i == 0) checkOutput("t6_first_drop", vec_t'(frame_drop), vec_t'(1));
      if (i == 99) checkOutput("t6_cnt100", vec_t'(drop_cnt), vec_t'(100));
      if (i == 253) checkOutput("t6_cnt254", vec_t'(drop_cnt), vec_t'(254));
      if (i == 254) checkOutput("t6_cnt255", vec_t'(drop_cnt), vec_t'(255));
      tick();
    end
    checkOutput("t6_cnt_sat", vec_t'(drop_cnt), vec_t'(255));
    checkOutput("t6_drop_clear", vec_t'(frame_drop), vec_t'(0));
    checkOutput("t6_first_frame_held", vec_t'(m_re), expBeat(1, 0, 1'b0));
    applyReset("reset_end");

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
